// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction per retirement and hands {pc, inst} to decode.
// Optional build macro IFU_ALIGN_CHECK_EN: a misaligned redirect is delivered as a fault instead of being force-aligned.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_pre_i,
  output logic        ready_pre_o,
  input  logic        branch_en_i,
  input  logic [31:0] dnpc_i,
  output logic        arvalid_o,
  input  logic        arready_i,
  output logic [31:0] araddr_o,
  input  logic        rvalid_i,
  output logic        rready_o,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  output logic        valid_post_o,
  input  logic        ready_post_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        fault_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    OUT  = 3'd3,
    WAIT = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic        fault_reg, fault_next;

  logic [31:0] redirect_pc;
  logic        redirect_misaligned;

`ifdef IFU_ALIGN_CHECK_EN
  assign redirect_pc         = dnpc_i;
  assign redirect_misaligned = (dnpc_i[1:0] != 2'b00);
`else
  // Low target bits are dropped: the redirect is silently word-aligned.
  logic dnpc_low_unused;
  assign dnpc_low_unused     = ^dnpc_i[1:0];
  assign redirect_pc         = {dnpc_i[31:2], 2'b00};
  assign redirect_misaligned = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      inst_reg  <= 32'h0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
      fault_reg <= fault_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    inst_next  = inst_reg;
    fault_next = fault_reg;
    case (state_reg)
      IDLE: state_next = AR;
      AR: begin
        if (arready_i) state_next = R;
      end
      R: begin
        if (rvalid_i) begin
          inst_next  = rdata_i;
          fault_next = (rresp_i != 2'b00);
          state_next = OUT;
        end
      end
      OUT: begin
        if (ready_post_i) state_next = WAIT;
      end
      WAIT: begin
        if (valid_pre_i) begin
          fault_next = 1'b0;
          state_next = AR;
          if (!branch_en_i) begin
            pc_next = pc_reg + 32'd4;
          end else if (redirect_misaligned) begin
            // Skip the bus entirely; decode receives the bad PC flagged as a fault.
            pc_next    = redirect_pc;
            inst_next  = 32'h0;
            fault_next = 1'b1;
            state_next = OUT;
          end else begin
            pc_next = redirect_pc;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs come from state alone, never combinationally from inputs.
  assign arvalid_o    = (state_reg == AR);
  assign rready_o     = (state_reg == R);
  assign valid_post_o = (state_reg == OUT);
  assign ready_pre_o  = (state_reg == WAIT);
  assign araddr_o     = pc_reg;
  assign pc_o         = pc_reg;
  assign inst_o       = inst_reg;
  assign fault_o      = fault_reg;

endmodule
